// File: rtl/calc_cu_pkg.sv
// Shared types and constants for the calculator control unit.
package calc_cu_pkg;

  localparam int unsigned ST_W   = 3;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned SEL_W  = 2;

  // Fixed register-file slots used by every transaction
  localparam logic [ADDR_W-1:0] RA = 2'd1;
  localparam logic [ADDR_W-1:0] RB = 2'd2;
  localparam logic [ADDR_W-1:0] RD = 2'd3;

  typedef enum logic [ST_W-1:0] {
    IDLE = 3'd0,
    WR_A = 3'd1,
    WR_B = 3'd2,
    EXEC = 3'd3,
    OUT  = 3'd4,
    DONE = 3'd5
  } state_e;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } op_e;

  typedef enum logic [SEL_W-1:0] {
    SEL_IN1 = 2'd0,
    SEL_IN2 = 2'd1,
    SEL_ALU = 2'd2
  } sel_e;

  // Control bundle driven towards the datapath
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic              rea;
    logic              reb;
    logic [ADDR_W-1:0] raa;
    logic [ADDR_W-1:0] rab;
    logic [OP_W-1:0]   c;
    logic [SEL_W-1:0]  s1;
    logic              s2;
    logic              done;
  } ctrl_t;

endpackage

// File: rtl/calc_cu_if.sv
// Host handshake plus datapath control lines of the calculator control unit.
interface calc_cu_if;
  import calc_cu_pkg::*;

  logic              go;
  logic [OP_W-1:0]   op;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic              rea;
  logic              reb;
  logic [ADDR_W-1:0] raa;
  logic [ADDR_W-1:0] rab;
  logic [OP_W-1:0]   c;
  logic [SEL_W-1:0]  s1;
  logic              s2;
  logic              done;
  logic [ST_W-1:0]   cs;

  modport master (
    output go, op,
    input  we, wa, rea, reb, raa, rab, c, s1, s2, done, cs
  );

  modport slave (
    input  go, op,
    output we, wa, rea, reb, raa, rab, c, s1, s2, done, cs
  );

endinterface

// File: rtl/calc_cu_decode.sv
// Pure Moore decode: current state and latched op to datapath controls.
module calc_cu_decode
  import calc_cu_pkg::*;
(
  input  logic [ST_W-1:0] i_cs,
  input  logic [OP_W-1:0] i_op,
  output ctrl_t           o_ctrl
);

  // Everything defaults low; each state raises only what it needs
  always_comb begin
    o_ctrl = '0;
    case (i_cs)
      WR_A: begin
        o_ctrl.we = 1'b1;
        o_ctrl.wa = RA;
        o_ctrl.s1 = SEL_IN1;
      end
      WR_B: begin
        o_ctrl.we = 1'b1;
        o_ctrl.wa = RB;
        o_ctrl.s1 = SEL_IN2;
      end
      EXEC: begin
        // Combinational RF reads feed the ALU; result lands in RD at the edge
        o_ctrl.rea = 1'b1;
        o_ctrl.reb = 1'b1;
        o_ctrl.raa = RA;
        o_ctrl.rab = RB;
        o_ctrl.c   = i_op;
        o_ctrl.s1  = SEL_ALU;
        o_ctrl.we  = 1'b1;
        o_ctrl.wa  = RD;
      end
      OUT: begin
        o_ctrl.rea = 1'b1;
        o_ctrl.raa = RD;
        o_ctrl.s2  = 1'b1;
      end
      DONE: begin
        o_ctrl.done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/calc_cu.sv
// Calculator control unit: sequences load A, load B, execute, output, handshake.
module calc_cu
  import calc_cu_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  calc_cu_if.slave  bus
);

  logic [ST_W-1:0] r_cs;
  logic [OP_W-1:0] r_op_q;
  logic [ST_W-1:0] w_nxt;
  ctrl_t           w_ctrl;

  // State and operation registers; op is captured only on the starting edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs   <= ST_W'(IDLE);
      r_op_q <= OP_W'(OP_ADD);
    end else begin
      r_cs <= w_nxt;
      if (r_cs == ST_W'(IDLE) && bus.go)
        r_op_q <= bus.op;
    end
  end

  // Next state; unused codes fall back to IDLE
  always_comb begin
    w_nxt = ST_W'(IDLE);
    case (r_cs)
      IDLE:    w_nxt = bus.go ? ST_W'(WR_A) : ST_W'(IDLE);
      WR_A:    w_nxt = ST_W'(WR_B);
      WR_B:    w_nxt = ST_W'(EXEC);
      EXEC:    w_nxt = ST_W'(OUT);
      OUT:     w_nxt = ST_W'(DONE);
      DONE:    w_nxt = bus.go ? ST_W'(DONE) : ST_W'(IDLE);
      default: w_nxt = ST_W'(IDLE);
    endcase
  end

  calc_cu_decode u_decode (
    .i_cs   (r_cs),
    .i_op   (r_op_q),
    .o_ctrl (w_ctrl)
  );

  assign bus.we   = w_ctrl.we;
  assign bus.wa   = w_ctrl.wa;
  assign bus.rea  = w_ctrl.rea;
  assign bus.reb  = w_ctrl.reb;
  assign bus.raa  = w_ctrl.raa;
  assign bus.rab  = w_ctrl.rab;
  assign bus.c    = w_ctrl.c;
  assign bus.s1   = w_ctrl.s1;
  assign bus.s2   = w_ctrl.s2;
  assign bus.done = w_ctrl.done;
  assign bus.cs   = r_cs;

endmodule
